mc_maindec: RTL and testbench

//  Multicycle MIPS main control FSM; sits directly upstream of the ALU decoder and drives its 3-bit aluop.

---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/mc_wait_timer.sv | 55 +++++
 rtl/mc_maindec.sv | 196 +++++++++++++++++++
 tb/tb_mc_maindec.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the multicycle MIPS main decoder: opcodes,
// ALU operation codes, datapath mux select codes and the FSM state type.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional feature macro: MAINDEC_IMM_LOGIC_EN adds the IMMEX state so that
// andi/ori/slti are executed instead of trapping.
package mips_ctrl_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // aluop codes consumed by the downstream ALU decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  // ALU B-operand select
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
`ifdef MAINDEC_IMM_LOGIC_EN
    ,
    S_IMMEX   = 4'd13
`endif
  } state_t;

  // ALU operation for the logical/compare immediates; anything that is not
  // andi or ori is treated as slti since only those three reach IMMEX.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALUOP_AND;
      OP_ORI:  return ALUOP_OR;
      default: return ALUOP_SLT;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait watchdog: counts consecutive cycles a memory access is stalled
// and flags a timeout in the cycle the TIMEOUT-th stall cycle is observed.
// Latency: timeout is combinational from the count and inputs. Backpressure: n/a.
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   mem_req     - a memory access is being requested this cycle
//   mem_ready   - the access completes this cycle
//   timeout     - this stall cycle is the TIMEOUT-th one (never set if TIMEOUT==0)
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  output logic timeout
);

  // The count only needs to reach TIMEOUT-1: the stall cycle seen with that
  // count is the one that fires, and firing clears the counter.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = mem_req & ~mem_ready;

  generate
    if (TIMEOUT == 0) begin : g_off
      assign timeout = 1'b0;
    end else begin : g_on
      assign timeout = waiting && (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    // Clearing on !mem_req also covers leaving a memory state.
    if (!waiting || timeout) begin
      cnt_d = '0;
    end else if (TIMEOUT != 0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback per opcode and drives datapath selects, strobes and aluop.
// Latency: one state per cycle; memory states stall on mem_ready, and a
// memory access stalled TIMEOUT cycles (TIMEOUT=0 disables) traps.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   op              - opcode from the instruction register
//   zero            - ALU zero flag (qualifies branches)
//   mem_ready       - memory completes the current access this cycle
//   mem_req, iord, memwrite, irwrite  - memory interface controls
//   regwrite, regdst, memtoreg        - register file write controls
//   alusrca, alusrcb, aluop           - ALU operand/operation selects
//   pcsrc, pcen                       - next-PC select and PC enable
//   err                               - sticky trap flag
// Optional feature macro: MAINDEC_IMM_LOGIC_EN (andi/ori/slti via IMMEX).
module mc_maindec
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       pcen,
  output logic       err
);

  state_t state_q, state_d;
  logic   err_q, err_d;

  logic req_raw;
  logic we_raw;
  logic ir_raw;
  logic rw_raw;
  logic pcwrite;
  logic branch;
  logic timeout;

  // Kept outside the main always_comb so the timer's timeout feedback into
  // the next-state logic is not a block-level combinational loop.
  assign req_raw = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (req_raw),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    state_d  = state_q;
    we_raw   = 1'b0;
    ir_raw   = 1'b0;
    rw_raw   = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ALUSRCB_RT;
    pcsrc    = PCSRC_ALU;
    aluop    = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        alusrcb = ALUSRCB_FOUR;
        // IR load and PC+4 only happen on the cycle the fetch completes.
        ir_raw  = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = ALUSRCB_IMMSH;  // precompute branch target
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MAINDEC_IMM_LOGIC_EN
          OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rw_raw   = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        we_raw = 1'b1;  // held for the whole access, commits on mem_ready
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_RTYPE;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw_raw  = 1'b1;
        regdst  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        state_d = S_IMMWB;
      end
`ifdef MAINDEC_IMM_LOGIC_EN
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        aluop   = imm_aluop(op);
        state_d = S_IMMWB;
      end
`endif
      S_IMMWB: begin
        rw_raw  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;  // absorbing until reset
      end
      default: begin
        state_d = S_TRAP;  // unreachable encodings are treated as a fault
      end
    endcase

    // A stalled access that hits the limit abandons the instruction.
    if (timeout) state_d = S_TRAP;

    err_d = err_q | (state_d == S_TRAP);
  end

  // Strobes are suppressed during reset so nothing is disturbed while the
  // state register still holds a stale value.
  assign mem_req  = req_raw & ~reset;
  assign memwrite = we_raw & ~reset;
  assign irwrite  = ir_raw & ~reset;
  assign regwrite = rw_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Randomized self-checking bench for mc_maindec. The reference model walks
// each instruction as a list of phases derived from its opcode, and gives
// the expected control word of every cycle from a per-phase table.
module tb_mc_maindec;

  localparam int unsigned TMO = 4;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_EXEC   = 6;
  localparam int P_ALUWB  = 7;
  localparam int P_BEQ    = 8;
  localparam int P_ADDIEX = 9;
  localparam int P_IMMWB  = 10;
  localparam int P_JUMP   = 11;
  localparam int P_IMMEX  = 12;
  localparam int P_TRAP   = 13;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg;
  logic       alusrca, pcen, err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  int n_chk = 0;
  int n_err = 0;
  int n_instr = 0;

  mc_maindec #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .pcen      (pcen),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic string pname(input int ph);
    case (ph)
      P_FETCH:  return "fetch";
      P_DECODE: return "decode";
      P_MEMADR: return "memadr";
      P_MEMRD:  return "memrd";
      P_MEMWB:  return "memwb";
      P_MEMWR:  return "memwr";
      P_EXEC:   return "execute";
      P_ALUWB:  return "aluwb";
      P_BEQ:    return "beq";
      P_ADDIEX: return "addiex";
      P_IMMWB:  return "immwb";
      P_JUMP:   return "jump";
      P_IMMEX:  return "immex";
      default:  return "trap";
    endcase
  endfunction

  // Expected control word:
  // {mem_req,iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,
  //  alusrcb[1:0],pcsrc[1:0],aluop[2:0],pcen,err}
  function automatic logic [16:0] exp_ctl(input int ph, input bit rdy, input bit z,
                                          input logic [5:0] o);
    logic req, io, mw, irw, rw, rd, m2r, sa, pw, br, er;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {req, io, mw, irw, rw, rd, m2r, sa, pw, br, er} = '0;
    sb = 2'd0; ps = 2'd0; ao = 3'd0;
    case (ph)
      P_FETCH:  begin req = 1; sb = 2'd1; irw = rdy; pw = rdy; end
      P_DECODE: begin sb = 2'd3; end
      P_MEMADR: begin sa = 1; sb = 2'd2; end
      P_MEMRD:  begin req = 1; io = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin req = 1; io = 1; mw = 1; end
      P_EXEC:   begin sa = 1; ao = 3'd2; end
      P_ALUWB:  begin rw = 1; rd = 1; end
      P_BEQ:    begin sa = 1; ao = 3'd1; ps = 2'd1; br = 1; end
      P_ADDIEX: begin sa = 1; sb = 2'd2; end
      P_IMMWB:  begin rw = 1; end
      P_JUMP:   begin ps = 2'd2; pw = 1; end
      P_IMMEX:  begin
        sa = 1; sb = 2'd2;
        ao = (o == 6'b001100) ? 3'd3 : (o == 6'b001101) ? 3'd4 : 3'd5;
      end
      default:  begin er = 1; end
    endcase
    return {req, io, mw, irw, rw, rd, m2r, sa, sb, ps, ao, pw | (br & z), er};
  endfunction

  // One cycle in a given phase: drive mem_ready, check at the falling edge.
  task automatic step(input int ph, input bit rdy);
    logic [16:0] got;
    mem_ready = rdy;
    @(negedge clk);
    got = {mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, aluop, pcen, err};
    chk($sformatf("i%0d_%s", n_instr, pname(ph)), {15'd0, got},
        {15'd0, exp_ctl(ph, rdy, zero, op)});
    @(posedge clk);
    #1;
  endtask

  // A memory phase stalls nwait cycles; the TMO-th stalled cycle traps.
  task automatic mem_phase(input int ph, input int nwait, output bit trapped);
    trapped = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      bit r;
      r = (k > nwait);
      step(ph, r);
      if (r) break;
      if (TMO != 0 && k == TMO) begin
        trapped = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_strobes", {27'd0, mem_req, memwrite, irwrite, regwrite, pcen}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic do_trap();
    for (int c = 0; c < 3; c++) step(P_TRAP, 1'($urandom));
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] o, input bit z, input int fw, input int mw);
    bit tr;
    n_instr++;
    op = o;
    zero = z;
    mem_phase(P_FETCH, fw, tr);
    if (tr) begin do_trap(); return; end
    step(P_DECODE, 1'($urandom));
    case (o)
      6'b100011: begin
        step(P_MEMADR, 1'($urandom));
        mem_phase(P_MEMRD, mw, tr);
        if (tr) begin do_trap(); return; end
        step(P_MEMWB, 1'($urandom));
      end
      6'b101011: begin
        step(P_MEMADR, 1'($urandom));
        mem_phase(P_MEMWR, mw, tr);
        if (tr) begin do_trap(); return; end
      end
      6'b000000: begin step(P_EXEC, 1'($urandom)); step(P_ALUWB, 1'($urandom)); end
      6'b000100: step(P_BEQ, 1'($urandom));
      6'b001000: begin step(P_ADDIEX, 1'($urandom)); step(P_IMMWB, 1'($urandom)); end
      6'b000010: step(P_JUMP, 1'($urandom));
      6'b001100, 6'b001101, 6'b001010: begin
`ifdef MAINDEC_IMM_LOGIC_EN
        step(P_IMMEX, 1'($urandom));
        step(P_IMMWB, 1'($urandom));
`else
        do_trap();
`endif
      end
      default: do_trap();
    endcase
  endtask

  logic [5:0] legal_ops [0:9];

  initial begin
    legal_ops[0] = 6'b100011; legal_ops[1] = 6'b101011; legal_ops[2] = 6'b000000;
    legal_ops[3] = 6'b000100; legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;
    legal_ops[6] = 6'b001100; legal_ops[7] = 6'b001101; legal_ops[8] = 6'b001010;
    legal_ops[9] = 6'b100011;
    reset = 1'b1;
    op = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    do_reset();

    // Directed cases
    run_instr(6'b100011, 1'b0, 0, 0);   // lw, no stalls
    run_instr(6'b000000, 1'b0, 0, 0);   // R-type
    run_instr(6'b000100, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b100011, 1'b0, 3, 2);   // fetch stalls 3 cycles, load stalls 2
    run_instr(6'b101011, 1'b0, 0, 3);   // store stall just under the limit
    run_instr(6'b101011, 1'b0, 0, 10);  // store timeout -> trap, then reset
    run_instr(6'b001101, 1'b0, 0, 0);   // ori
    run_instr(6'b001100, 1'b0, 0, 0);   // andi
    run_instr(6'b001010, 1'b0, 0, 0);   // slti
    run_instr(6'b001000, 1'b0, 0, 0);   // addi
    run_instr(6'b000010, 1'b0, 0, 0);   // j
    run_instr(6'b111111, 1'b0, 0, 0);   // illegal opcode
    run_instr(6'b100011, 1'b0, 7, 0);   // fetch timeout
    run_instr(6'b100011, 1'b0, 0, 9);   // load timeout

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o;
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      else o = legal_ops[$urandom_range(0, 9)];
      run_instr(o, 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
